// File: rtl/fetch_sequencer.sv
// Next-PC selection and instruction-fetch handshake sequencer.
// Picks the next PC source (sequential, branch, jump, trap, mret), drives the
// active-low PC load strobe, runs the imem request handshake, flushes IF/ID on
// redirects and parks a redirect that lands while a fetch is still outstanding.
module fetch_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap,
    input  logic [WIDTH-1:0] trap_vector,
    input  logic             mret,
    input  logic [WIDTH-1:0] epc,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_en_n,
    output logic             imem_req,
    output logic             fetch_valid,
    output logic             flush_if,
    output logic             misaligned
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StWait
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             misaligned_q, misaligned_d;

    logic             redir;
    logic [WIDTH-1:0] redir_raw;
    logic [WIDTH-1:0] redir_target;
    logic             redir_odd;
    logic             redir_taken;
    logic [WIDTH-1:0] pc_plus4;

    assign redir        = trap | mret | jump | branch_taken;
    assign redir_target = {redir_raw[WIDTH-1:2], 2'b00};
    assign redir_odd    = |redir_raw[1:0];
    assign pc_plus4     = pc + WIDTH'(4);
    assign misaligned   = misaligned_q;

    // Redirect target mux: trap > mret > jump > branch.
    always_comb begin
        redir_raw = branch_target;
        if (trap) begin
            redir_raw = trap_vector;
        end else if (mret) begin
            redir_raw = epc;
        end else if (jump) begin
            redir_raw = jump_target;
        end
    end

    // Next-state and Mealy outputs; reset forces the idle output set.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        pc_next       = pc;
        pc_en_n       = 1'b1;
        imem_req      = 1'b0;
        fetch_valid   = 1'b0;
        flush_if      = 1'b0;
        redir_taken   = 1'b0;

        if (!reset) begin
            pc_next = RESET_VECTOR;
        end else begin
            unique case (state_q)
                StBoot: begin
                    // Redirects are ignored while the PC register settles.
                    pc_next = RESET_VECTOR;
                    state_d = StRun;
                end

                StRun: begin
                    imem_req = ~stall;
                    if (redir) begin
                        redir_taken = 1'b1;
                        flush_if    = 1'b1;
                        if (stall || imem_ready) begin
                            // No fetch in flight (or it just finished): apply now.
                            pc_next = redir_target;
                            pc_en_n = 1'b0;
                        end else begin
                            pend_target_d = redir_target;
                            pend_d        = 1'b1;
                            state_d       = StWait;
                        end
                    end else if (!stall) begin
                        if (imem_ready) begin
                            fetch_valid = 1'b1;
                            pc_next     = pc_plus4;
                            pc_en_n     = 1'b0;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end

                StWait: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        state_d = StRun;
                        pend_d  = 1'b0;
                        if (redir) begin
                            // Fresh redirect wins; the fetched word is dropped.
                            redir_taken = 1'b1;
                            flush_if    = 1'b1;
                            pc_next     = redir_target;
                            pc_en_n     = 1'b0;
                        end else if (pend_q) begin
                            flush_if = 1'b1;
                            pc_next  = pend_target_q;
                            pc_en_n  = 1'b0;
                        end else begin
                            fetch_valid = 1'b1;
                            if (!stall) begin
                                pc_next = pc_plus4;
                                pc_en_n = 1'b0;
                            end
                        end
                    end else if (redir) begin
                        // Latest redirect overwrites whatever is parked.
                        redir_taken   = 1'b1;
                        flush_if      = 1'b1;
                        pend_target_d = redir_target;
                        pend_d        = 1'b1;
                    end
                end

                default: begin
                    state_d = StBoot;
                end
            endcase
        end
    end

    // Misaligned pulse flags any accepted redirect whose low bits were dropped.
    always_comb begin
        misaligned_d = redir_taken & redir_odd;
    end

    // State, pending redirect and misaligned pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StBoot;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            misaligned_q  <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an external PC register and a
// fetch scoreboard: expected fetch addresses are queued when stimulus is
// driven and popped whenever fetch_valid is seen.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic        mret;
    logic [31:0] epc;
    logic        imem_ready;
    logic [31:0] pc_next;
    logic        pc_en_n;
    logic        imem_req;
    logic        fetch_valid;
    logic        flush_if;
    logic        misaligned;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .trap_vector   (trap_vector),
        .mret          (mret),
        .epc           (epc),
        .imem_ready    (imem_ready),
        .pc_next       (pc_next),
        .pc_en_n       (pc_en_n),
        .imem_req      (imem_req),
        .fetch_valid   (fetch_valid),
        .flush_if      (flush_if),
        .misaligned    (misaligned)
    );

    // PC register: loads pc_next while the active-low enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'h0;
        end else if (!pc_en_n) begin
            pc <= pc_next;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Fetch scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1 && fetch_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0)
            else begin
                errors++;
                $error("FAIL fetch_unexpected observed pc=%h expected no fetch_valid", pc);
            end
            if (exp_q.size() > 0) chk("fetch_pc", pc, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
        trap = 1'b0; trap_vector = '0; mret = 1'b0; epc = '0;

        // Reset state.
        @(negedge clk);
        chk("rst_pc_en_n", 32'(pc_en_n), 32'd1);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_flush_if", 32'(flush_if), 32'd0);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        next_cycle();
        reset = 1'b1;

        // One BOOT cycle, then sequential fetch.
        @(negedge clk);
        chk("boot_pc_en_n", 32'(pc_en_n), 32'd1);
        chk("boot_imem_req", 32'(imem_req), 32'd0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i * 4));
            @(negedge clk);
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_pc_next", pc_next, 32'(i * 4 + 4));
            next_cycle();
        end
        chk("seq_end_pc", pc, 32'h10);

        // Jump beats branch; then trap beats both.
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200;
        @(negedge clk);
        chk("prio_jump_pc_next", pc_next, 32'h200);
        chk("prio_jump_flush", 32'(flush_if), 32'd1);
        chk("prio_jump_fv", 32'(fetch_valid), 32'd0);
        next_cycle();
        chk("prio_jump_pc", pc, 32'h200);
        trap = 1'b1; trap_vector = 32'h80;
        @(negedge clk);
        chk("prio_trap_pc_next", pc_next, 32'h80);
        chk("prio_trap_flush", 32'(flush_if), 32'd1);
        next_cycle();
        branch_taken = 1'b0; jump = 1'b0; trap = 1'b0;
        chk("prio_trap_pc", pc, 32'h80);

        // Move to 0x20, then branch while the fetch is outstanding.
        jump = 1'b1; jump_target = 32'h20;
        next_cycle();
        jump = 1'b0;
        chk("goto_20", pc, 32'h20);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        chk("pend_pc_en_n", 32'(pc_en_n), 32'd1);
        chk("pend_flush", 32'(flush_if), 32'd1);
        chk("pend_imem_req", 32'(imem_req), 32'd1);
        next_cycle();
        branch_taken = 1'b0;
        @(negedge clk);
        chk("wait_imem_req", 32'(imem_req), 32'd1);
        chk("wait_pc_hold1", pc, 32'h20);
        next_cycle();
        @(negedge clk);
        chk("wait_pc_hold2", pc, 32'h20);
        next_cycle();
        imem_ready = 1'b1;
        @(negedge clk);
        chk("pend_done_fv", 32'(fetch_valid), 32'd0);
        chk("pend_done_flush", 32'(flush_if), 32'd1);
        chk("pend_done_pc_next", pc_next, 32'h40);
        chk("pend_done_pc_en_n", 32'(pc_en_n), 32'd0);
        next_cycle();
        chk("pend_done_pc", pc, 32'h40);

        // Trap mid-WAIT replaces a parked branch target.
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
        next_cycle();
        branch_taken = 1'b0; trap = 1'b1; trap_vector = 32'h84;
        next_cycle();
        trap = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("preempt_pc_next", pc_next, 32'h84);
        chk("preempt_flush", 32'(flush_if), 32'd1);
        next_cycle();
        chk("preempt_pc", pc, 32'h84);

        // Stall at 0x30, then branch during stall.
        jump = 1'b1; jump_target = 32'h30;
        next_cycle();
        jump = 1'b0;
        chk("goto_30", pc, 32'h30);
        stall = 1'b1;
        @(negedge clk);
        chk("stall_imem_req", 32'(imem_req), 32'd0);
        chk("stall_pc_en_n", 32'(pc_en_n), 32'd1);
        chk("stall_fv", 32'(fetch_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("stall_pc_hold", pc, 32'h30);
        chk("stall_imem_req2", 32'(imem_req), 32'd0);
        next_cycle();
        branch_taken = 1'b1; branch_target = 32'h50;
        @(negedge clk);
        chk("stall_br_pc_next", pc_next, 32'h50);
        chk("stall_br_pc_en_n", 32'(pc_en_n), 32'd0);
        chk("stall_br_flush", 32'(flush_if), 32'd1);
        next_cycle();
        branch_taken = 1'b0; stall = 1'b0;
        chk("stall_br_pc", pc, 32'h50);

        // Misaligned jump target, then a plain WAIT completion.
        jump = 1'b1; jump_target = 32'h103;
        @(negedge clk);
        chk("mis_pc_next", pc_next, 32'h100);
        chk("mis_before", 32'(misaligned), 32'd0);
        next_cycle();
        jump = 1'b0;
        chk("mis_pc", pc, 32'h100);
        chk("mis_pulse", 32'(misaligned), 32'd1);
        imem_ready = 1'b0;
        @(negedge clk);
        chk("wait_in_pc_en_n", 32'(pc_en_n), 32'd1);
        chk("wait_in_imem_req", 32'(imem_req), 32'd1);
        next_cycle();
        chk("mis_cleared", 32'(misaligned), 32'd0);
        imem_ready = 1'b1;
        exp_q.push_back(32'h100);
        @(negedge clk);
        chk("wait_done_pc_next", pc_next, 32'h104);
        chk("wait_done_pc_en_n", 32'(pc_en_n), 32'd0);
        next_cycle();
        chk("wait_done_pc", pc, 32'h104);

        // Wrap from the top of the address space.
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        next_cycle();
        jump = 1'b0;
        chk("goto_top", pc, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc_next", pc_next, 32'h0);
        next_cycle();
        chk("wrap_pc", pc, 32'h0);

        // Reset while waiting with a parked redirect.
        jump = 1'b1; jump_target = 32'h60;
        next_cycle();
        jump = 1'b0;
        chk("goto_60", pc, 32'h60);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        next_cycle();
        branch_taken = 1'b0;
        #1;
        chk("rstwait_imem_req_pre", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstwait_imem_req", 32'(imem_req), 32'd0);
        chk("rstwait_pc_en_n", 32'(pc_en_n), 32'd1);
        chk("rstwait_pc", pc, 32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        chk("rstwait_boot_pc_en_n", 32'(pc_en_n), 32'd1);
        next_cycle();
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("rstwait_no_flush", 32'(flush_if), 32'd0);
        chk("rstwait_pc_next", pc_next, 32'h4);
        next_cycle();
        chk("rstwait_pc_after", pc, 32'h4);

        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL fetch_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter register. That register loads `pc_next` on a clock edge when its enable input is low, and clears to 0 on reset.
- Each cycle this block selects the next-PC source: sequential, branch, jump, trap, or mret.
- It produces the active-low PC load strobe and runs the instruction-memory request handshake.
- It flushes the IF stage on redirects and holds a redirect that arrives while a fetch is still outstanding until that fetch completes.

Parameters:
- WIDTH, 32, address width of the PC and all targets.
- RESET_VECTOR, 32'h00000000, first fetch address. Must equal the PC register reset value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pc  in  WIDTH  current PC register output
- stall  in  1  hazard-unit stall; hold PC, no new fetch
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  WIDTH  branch destination
- jump  in  1  JAL/JALR in EX
- jump_target  in  WIDTH  jump destination
- trap  in  1  exception or interrupt taken
- trap_vector  in  WIDTH  mtvec value
- mret  in  1  return from trap
- epc  in  WIDTH  mepc value
- imem_ready  in  1  instruction memory completes the current request
- pc_next  out  WIDTH  next-PC value to the PC register
- pc_en_n  out  1  PC load strobe; 0 = load `pc_next`, 1 = hold
- imem_req  out  1  fetch request for address `pc`
- fetch_valid  out  1  instruction on the memory bus is valid for IF/ID
- flush_if  out  1  kill the IF/ID contents this cycle
- misaligned  out  1  registered one-cycle pulse: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (async, `reset`=0):
  - State goes to BOOT; the pending flag and `pend_target` clear to 0; `misaligned` goes to 0.
  - Combinational outputs during reset: `pc_en_n`=1, `imem_req`=0, `fetch_valid`=0, `flush_if`=0, `pc_next`=RESET_VECTOR.
- Redirect priority: trap > mret > jump > branch_taken.
  - `redir` = OR of the four inputs. `redir_target` is the winning target.
  - Bits[1:0] of `redir_target` are forced to 0. If they were nonzero, `misaligned` is set for the next cycle.
- Output timing: `pc_next`, `pc_en_n`, `imem_req`, `fetch_valid` and `flush_if` are combinational (Mealy) from state and inputs. The PC register updates on the same clock edge, so redirect latency is zero cycles.
- State BOOT:
  - `pc_en_n`=1, `imem_req`=0. Advances to RUN unconditionally after one cycle.
  - A `redir` in BOOT is ignored.
- State RUN:
  - redir with `imem_ready`=1, or with no fetch issued: `pc_next`=redir_target, `pc_en_n`=0, `flush_if`=1, `fetch_valid`=0. Stays in RUN.
  - redir with `imem_req`=1 and `imem_ready`=0: latch redir_target into `pend_target`, set pend, hold with `pc_en_n`=1 and `flush_if`=1, go to WAIT.
  - Redirect overrides stall.
  - stall=1, no redir: `imem_req`=0, `pc_en_n`=1, `fetch_valid`=0.
  - Otherwise `imem_req`=1:
    - `imem_ready`=1: `fetch_valid`=1, `pc_next`=pc+4 (mod 2^WIDTH, wraps 0xFFFFFFFC to 0), `pc_en_n`=0.
    - `imem_ready`=0: `pc_en_n`=1, go to WAIT.
- State WAIT:
  - `imem_req` stays 1 and `pc` is held.
  - A new redir arriving while in WAIT overwrites `pend_target` and sets pend (last-highest-priority wins in that cycle).
  - On `imem_ready`=1 with pend set: `fetch_valid`=0, `pc_next`=pend_target, `pc_en_n`=0, `flush_if`=1, clear pend, go to RUN.
  - On `imem_ready`=1 with pend clear: `fetch_valid`=1, go to RUN. If stall=0, advance `pc_next`=pc+4, `pc_en_n`=0. If stall=1, hold the PC (`pc_en_n`=1).
  - A redir arriving in the same cycle as `imem_ready` is applied directly; the fetched word is discarded.
- A trap arriving mid-WAIT preempts any pending branch target.
- Reset asserted mid-WAIT abandons the request: `imem_req` drops asynchronously.

Test Plan:
- Reset release with `imem_ready` tied 1 -> one BOOT cycle with `pc_en_n`=1, then `pc` steps 0, 4, 8, 12 with `fetch_valid`=1 each cycle.
- At pc=0x10, `branch_taken`=1 with target 0x100 and `jump`=1 with target 0x200 in the same cycle -> `pc_next`=0x200, `flush_if`=1; next cycle pc=0x200. Repeat with `trap`=1 and trap_vector=0x80 added -> pc=0x80.
- `imem_ready`=0 for 3 cycles at pc=0x20, branch to 0x40 in the first cycle -> pc holds 0x20, `fetch_valid`=0 on completion, then pc=0x40, `flush_if`=1 on completion.
- `stall`=1 for 2 cycles at pc=0x30 -> `imem_req`=0, pc stays 0x30. Branch during stall to 0x50 -> pc=0x50 next edge.
- Jump target 0x103 -> pc=0x100 and a one-cycle `misaligned` pulse. At pc=0xFFFFFFFC with no redirect -> pc=0x00000000.
- Reset pulled low in WAIT with pend set -> `imem_req`=0 immediately; after release pc=0 and pend is clear.
